// File: rtl/tt_pad_loopback_tester_if.sv
// Control, status and pad-buffer signals of the pad loopback tester.
interface tt_pad_loopback_tester_if;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned IDX_W = 5;

  logic             start;
  logic             abort;
  logic             Y_in;
  logic             A_out;
  logic             OE_out;
  logic             IE_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_fail;
  logic             first_fail_valid;

  // Requester side: issues commands, closes the pad loop, reads results.
  modport master (
    output start, abort, Y_in,
    input  A_out, OE_out, IE_out, busy, done, pass,
           err_count, first_fail, first_fail_valid
  );

  // Tester side.
  modport slave (
    input  start, abort, Y_in,
    output A_out, OE_out, IE_out, busy, done, pass,
           err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/tt_pad_loopback_tester.sv
// Pad loopback tester: drives a fixed bit pattern onto a pad buffer, lets each
// vector settle, samples the synchronized receive path and records mismatches.
module tt_pad_loopback_tester #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_VECTORS   = 16,
  parameter logic [31:0] PATTERN       = 32'h0000A5C3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tt_pad_loopback_tester_if.slave     bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             y_meta;
  logic             y_sync;

  logic             mismatch_c;
  logic [IDX_W-1:0] idx_next_c;
  logic [ERR_W-1:0] err_inc_c;

  assign mismatch_c = (y_sync != PATTERN[idx]);
  assign idx_next_c = idx + IDX_W'(1);
  assign err_inc_c  = (bus.err_count == ERR_MAX) ? ERR_MAX : bus.err_count + ERR_W'(1);

  // Two-flop synchronizer on the asynchronous pad receive path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      y_meta <= bus.Y_in;
      y_sync <= y_meta;
    end
  end

  // Run sequencer with registered pad controls and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      idx                  <= '0;
      cnt                  <= '0;
      bus.A_out            <= 1'b0;
      bus.OE_out           <= 1'b0;
      bus.IE_out           <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.err_count        <= '0;
      bus.first_fail       <= '0;
      bus.first_fail_valid <= 1'b0;
    end else if (bus.abort) begin
      // Abort releases the pad but keeps the partial results visible.
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      bus.A_out  <= 1'b0;
      bus.OE_out <= 1'b0;
      bus.IE_out <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.pass   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state                <= SETTLE;
            idx                  <= '0;
            cnt                  <= '0;
            bus.A_out            <= PATTERN[0];
            bus.OE_out           <= 1'b1;
            bus.IE_out           <= 1'b1;
            bus.busy             <= 1'b1;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.err_count        <= '0;
            bus.first_fail       <= '0;
            bus.first_fail_valid <= 1'b0;
          end
        end

        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (mismatch_c) begin
            bus.err_count <= err_inc_c;
            if (!bus.first_fail_valid) begin
              bus.first_fail       <= idx;
              bus.first_fail_valid <= 1'b1;
            end
          end
          if (idx == IDX_LAST) begin
            state      <= DONE;
            bus.A_out  <= 1'b0;
            bus.OE_out <= 1'b0;
            bus.IE_out <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.pass   <= (bus.err_count == '0) && !mismatch_c;
          end else begin
            state     <= SETTLE;
            idx       <= idx_next_c;
            cnt       <= '0;
            bus.A_out <= PATTERN[idx_next_c];
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tt_pad_loopback_tester.md
TT_PAD_LOOPBACK_TESTER -- requirements
Module: tt_pad_loopback_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles between driving a vector and sampling it; legal range 2..255, ≥ synchronizer depth.
REQ-002 Parameter NUM_VECTORS, default 16, number of test vectors per run; legal range 1..32.
REQ-003 Parameter PATTERN, default 32'h0000A5C3, expected pad value for vector i is PATTERN[i].
REQ-004 clk  input  1  single block clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle run request, sampled in IDLE or DONE only.
REQ-007 abort  input  1  cancels any run, returns to IDLE.
REQ-008 Y_in  input  1  pad receive path from the buffer macro, asynchronous to clk.
REQ-009 A_out  output  1  pad drive data to the buffer macro.
REQ-010 OE_out  output  1  pad output enable to the buffer macro.
REQ-011 IE_out  output  1  pad input enable to the buffer macro.
REQ-012 busy  output  1  high in SETTLE and SAMPLE.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  valid while done=1; 1 iff err_count==0.
REQ-015 err_count  output  8  mismatching vectors in current/last run, saturating at 255.
REQ-016 first_fail  output  5  index of first mismatching vector; 0 if none.
REQ-017 first_fail_valid  output  1  high once any mismatch recorded this run.

Function
REQ-018 Y_in SHALL pass through a 2-flop synchronizer (reset 0) before comparison; y_sync is its output.
REQ-019 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; all outputs SHALL be registered.
REQ-020 IDLE/DONE with start=1, abort=0: next cycle SETTLE, idx=0, cnt=0, err_count=0, first_fail=0, first_fail_valid=0, A_out=PATTERN[0], OE_out=1, IE_out=1.
REQ-021 SETTLE: cnt increments each cycle; cnt==SETTLE_CYCLES-1 -> SAMPLE next cycle.
REQ-022 SAMPLE (one cycle): mismatch when y_sync != PATTERN[idx]; mismatch increments err_count (saturating) and, if first_fail_valid=0, sets first_fail=idx and first_fail_valid=1.
REQ-023 SAMPLE with idx<NUM_VECTORS-1: next cycle SETTLE, idx+1, cnt=0, A_out=PATTERN[idx+1], OE/IE held 1.
REQ-024 SAMPLE with idx==NUM_VECTORS-1: next cycle DONE, A_out=0, OE_out=0, IE_out=0.
REQ-025 Run length SHALL be exactly NUM_VECTORS*(SETTLE_CYCLES+1) cycles from first SETTLE cycle to first DONE cycle.
REQ-026 DONE SHALL hold results and pass until start (restart per REQ-020) or abort.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort=1 in any state SHALL force IDLE next cycle with A_out=0, OE_out=0, IE_out=0, done=0; err_count/first_fail retain values; abort wins over simultaneous start.
REQ-029 In IDLE, OE_out=0, IE_out=0, A_out=0 (pad released).

Reset
REQ-030 rst_n low SHALL immediately force IDLE, A_out=0, OE_out=0, IE_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0, synchronizer=0, idx=0, cnt=0, including mid-run.
REQ-031 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification (defaults: SETTLE_CYCLES=4, NUM_VECTORS=16, PATTERN=32'hA5C3)
REQ-032 Y_in = A_out delayed 1 cycle, pulse start -> done after exactly 80 cycles, pass=1, err_count=0, first_fail_valid=0.
REQ-033 Y_in stuck 0, start -> done after 80 cycles, pass=0, err_count=8, first_fail=0, first_fail_valid=1.
REQ-034 Y_in stuck 1, start -> err_count=8, first_fail=2, pass=0.
REQ-035 Loopback run, abort during vector 7 -> IDLE next cycle, OE_out=0, IE_out=0, done=0; re-start -> full passing run in 80 cycles.
REQ-036 rst_n pulsed low during vector 3 -> all outputs zero immediately; start pulse during busy in a later run -> ignored, run length still 80 cycles.
